// File: rtl/pixel_result_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_result_serializer                                                  |
// | Buffers result words in a FIFO and streams them out MSB byte first.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_result_serializer #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic [7:0]       byteOut,
  output logic             byteValid,
  input  logic             byteReady,
  output logic             fifoFull,
  output logic             overflow,
  output logic             busy
);

  localparam int BYTES = WIDTH / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic w_not_empty;
  logic w_full;
  logic w_transfer;
  logic w_last_byte;
  logic w_pop;
  logic w_push;

  assign w_not_empty = (count_q != '0);
  assign w_full      = (count_q == CNT_W'(DEPTH));
  assign w_transfer  = (state_q == ST_SEND) && byteReady;
  assign w_last_byte = (byte_idx_q == IDX_W'(BYTES - 1));

  // A pop happens either to start from idle or to chain the next word with no bubble.
  assign w_pop  = w_not_empty &&
                  ((state_q == ST_IDLE) || (w_transfer && w_last_byte));
  assign w_push = validIn && (!w_full || w_pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (validIn && !w_push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (w_pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_transfer) begin
          if (!w_last_byte) begin
            shift_d    = shift_q << 8;
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end else if (w_pop) begin
            shift_d    = mem_q[rd_ptr_q];
            byte_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  assign byteValid = (state_q == ST_SEND);
  assign byteOut   = shift_q[WIDTH-1 -: 8];
  assign fifoFull  = w_full;
  assign overflow  = overflow_q;
  assign busy      = byteValid || w_not_empty;

endmodule
`default_nettype wire
